uart_rx_buf_ctrl: RTL and testbench
===================================

Name: uart_rx_buf_ctrl

Overview:
Receive-side controller placed between the UART receiver and the system bus.
- Captures each completed character from the receiver (done pulse plus parallel data) into an internal circular FIFO.
- Provides first-word-fall-through read access, sticky overflow detection, a programmable fill-level interrupt, and a character-timeout interrupt timed from the shared oversampling tick.

Parameters:
DBits, 8, data width per character; must match the receiver.
ADDR_W, 4, FIFO address width; depth = 2**ADDR_W.
TO_TICKS, 640, S_tick count with no new character before timeout fires (4 chars x 10 bits x 16).

Ports:
clk  input  1  system clock
areset  input  1  asynchronous active-low reset
S_tick  input  1  oversampling tick (16 per bit), one clk wide
Rx_done_Tick  input  1  receiver character-complete pulse, one clk wide
Rx_Dout  input  DBits  received character, valid when Rx_done_Tick=1
rd_en  input  1  pop request from consumer
rd_data  output  DBits  head of FIFO, valid while empty=0
empty  output  1  FIFO holds 0 entries
full  output  1  FIFO holds 2**ADDR_W entries
count  output  ADDR_W+1  current occupancy
rx_thresh  input  ADDR_W+1  fill-level threshold; 0 disables
thresh_irq  output  1  level: count >= rx_thresh and rx_thresh != 0
overflow  output  1  sticky: a character was dropped because the FIFO was full
overflow_clr  input  1  clears overflow
timeout_irq  output  1  level: character timeout

Behaviour:
- Reset (areset=0, asynchronous):
  - wr_ptr=rd_ptr=0, count=0, empty=1, full=0.
  - overflow=0, timeout_irq=0, timer=0, timeout FSM in T_IDLE.
  - rd_data=0; memory contents are not reset.
- Reset may assert at any time. All state is discarded, including a partially timed timeout and stored data.
- Write:
  - On Rx_done_Tick=1 with full=0: mem[wr_ptr]<=Rx_Dout; wr_ptr increments and wraps modulo 2**ADDR_W.
  - On Rx_done_Tick=1 with full=1: data is dropped, pointers unchanged, overflow<=1.
- Read:
  - rd_data is mem[rd_ptr] (first-word fall-through). Data written at edge N is visible on rd_data after edge N when the FIFO was empty.
  - rd_en=1 with empty=0 increments rd_ptr with wrap.
  - rd_en=1 with empty=1 is ignored and has no error side effect.
- Simultaneous write and read:
  - FIFO full: the read pops and the write is accepted, count unchanged, no overflow.
  - FIFO empty: the write is accepted and the read is ignored, count becomes 1.
  - Otherwise: both are performed, count unchanged.
- count, empty and full are registered and consistent with the pointers every cycle. full = (count == 2**ADDR_W).
- overflow clear: overflow_clr=1 clears overflow. If it coincides with a new drop, set wins (overflow stays 1).
- thresh_irq is combinational from count and rx_thresh.
- Timeout FSM, counter timer of width clog2(TO_TICKS):
  - T_IDLE: timer=0. An accepted write goes to T_COUNT.
  - T_COUNT:
    - Any Rx_done_Tick resets timer=0 and stays in T_COUNT.
    - empty becoming 1 goes to T_IDLE.
    - Otherwise each S_tick increments timer.
    - On S_tick with timer==TO_TICKS-1: go to T_FIRED and set timeout_irq=1.
  - T_FIRED, timeout_irq=1:
    - An accepted write clears the irq, resets timer and goes to T_COUNT.
    - Any rd_en pop clears the irq: go to T_IDLE if the FIFO becomes empty, else T_COUNT with timer=0.
  - Priority within a cycle: reset > write > read > tick.
- Latency: Rx_done_Tick to empty=0 is 1 clk. rd_en to next rd_data is 1 clk.

Test Plan:
- Reset, then write 0xA5 -> after 1 clk empty=0, count=1, rd_data=0xA5. rd_en for 1 clk -> empty=1, count=0.
- Write 16 chars 0x00..0x0F (ADDR_W=4) -> full=1, count=16. A 17th char 0xFF -> dropped, overflow=1. Read all 16 -> data 0x00..0x0F in order, no 0xFF. overflow_clr -> overflow=0.
- Wrap-around: write/read 40 chars interleaved with occupancy kept at 3 -> data order preserved; pointers wrap twice; count never exceeds 3.
- Full FIFO with Rx_done_Tick and rd_en in the same cycle -> count stays 16, overflow stays 0, new char read last.
- rx_thresh=4: write 3 chars -> thresh_irq=0; 4th -> thresh_irq=1; read 1 -> 0. With rx_thresh=0 -> thresh_irq stays 0 at 16 entries.
- Write 2 chars, then supply 639 S_ticks -> timeout_irq=0; 640th -> timeout_irq=1. A single rd_en -> irq clears and count=1. areset pulse mid-count -> all outputs return to reset values.

Source files
------------

// File: rtl/uart_rx_buf_ctrl_if.sv
// Bus between the UART receiver/consumer side and the receive buffer controller.
// Handshake: a character is offered for exactly the one cycle Rx_done_Tick=1; a pop happens on a cycle with rd_en=1 and empty=0.
interface uart_rx_buf_ctrl_if #(
    parameter int DBits  = 8,
    parameter int ADDR_W = 4
);
    logic              Rx_done_Tick;
    logic [DBits-1:0]  Rx_Dout;
    logic              rd_en;
    logic [DBits-1:0]  rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   rx_thresh;
    logic              thresh_irq;
    logic              overflow;
    logic              overflow_clr;
    logic              timeout_irq;

    modport master (
        output Rx_done_Tick, Rx_Dout, rd_en, rx_thresh, overflow_clr,
        input  rd_data, empty, full, count, thresh_irq, overflow, timeout_irq
    );

    modport slave (
        input  Rx_done_Tick, Rx_Dout, rd_en, rx_thresh, overflow_clr,
        output rd_data, empty, full, count, thresh_irq, overflow, timeout_irq
    );
endinterface

// File: rtl/uart_rx_buf_ctrl.sv
// UART receive buffer: circular FWFT FIFO with sticky overflow, fill-level
// interrupt and a character-timeout interrupt timed in S_tick units.
module uart_rx_buf_ctrl #(
    parameter int DBits    = 8,
    parameter int ADDR_W   = 4,
    parameter int TO_TICKS = 640
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                S_tick,
    uart_rx_buf_ctrl_if.slave   bus,
    output logic [1:0]          dbg_state
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int TW    = $clog2(TO_TICKS);

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_COUNT = 2'd1,
        T_FIRED = 2'd2
    } t_state_e;

    logic [DBits-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic              empty_q, full_q, overflow_q;
    logic              wr_acc, rd_acc, drop, empty_nxt;
    t_state_e          state, state_nxt;
    logic [TW-1:0]     timer, timer_nxt;

    // A full FIFO still accepts a write when the same cycle pops a slot.
    assign rd_acc    = bus.rd_en && !empty_q;
    assign wr_acc    = bus.Rx_done_Tick && (!full_q || bus.rd_en);
    assign drop      = bus.Rx_done_Tick && !wr_acc;
    assign cnt_nxt   = cnt + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    assign empty_nxt = (cnt_nxt == '0);

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.Rx_Dout;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            cnt     <= cnt_nxt;
            empty_q <= empty_nxt;
            full_q  <= (cnt_nxt == (ADDR_W+1)'(DEPTH));
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop)                  overflow_q <= 1'b1;
            else if (bus.overflow_clr) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state <= T_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Priority inside a cycle: write, then read, then tick.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        unique case (state)
            T_IDLE: begin
                timer_nxt = '0;
                if (wr_acc) state_nxt = T_COUNT;
            end
            T_COUNT: begin
                if (bus.Rx_done_Tick) begin
                    timer_nxt = '0;
                end else if (empty_nxt) begin
                    state_nxt = T_IDLE;
                    timer_nxt = '0;
                end else if (S_tick) begin
                    if (timer == TW'(TO_TICKS - 1)) begin
                        state_nxt = T_FIRED;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end
            T_FIRED: begin
                if (wr_acc) begin
                    state_nxt = T_COUNT;
                    timer_nxt = '0;
                end else if (rd_acc) begin
                    state_nxt = empty_nxt ? T_IDLE : T_COUNT;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = T_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    assign bus.rd_data     = empty_q ? '0 : mem[rd_ptr];
    assign bus.empty       = empty_q;
    assign bus.full        = full_q;
    assign bus.count       = cnt;
    assign bus.overflow    = overflow_q;
    assign bus.thresh_irq  = (bus.rx_thresh != '0) && (cnt >= bus.rx_thresh);
    assign bus.timeout_irq = (state == T_FIRED);
    assign dbg_state       = state;
endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Bench for uart_rx_buf_ctrl: hand vectors, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_uart_rx_buf_ctrl;
  localparam int DBITS    = 8;
  localparam int AW       = 4;
  localparam int DEPTH    = 16;
  localparam int TO_TICKS = 640;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic       S_tick = 1'b0;
  logic [1:0] dbg_state;

  uart_rx_buf_ctrl_if #(.DBits(DBITS), .ADDR_W(AW)) bus ();

  uart_rx_buf_ctrl #(.DBits(DBITS), .ADDR_W(AW), .TO_TICKS(TO_TICKS)) dut (
    .clk       (clk),
    .areset    (areset),
    .S_tick    (S_tick),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model
  logic [DBITS-1:0] m_q[$];
  bit               m_ovf;
  bit               m_fired;
  int               m_silent;
  logic [AW:0]      m_thr;

  task automatic model_reset();
    m_q.delete();
    m_ovf    = 0;
    m_fired  = 0;
    m_silent = 0;
  endtask

  task automatic model_step(input logic done, input logic [7:0] din, input logic rd,
                            input logic tick, input logic clr);
    int n;
    bit pop;
    bit acc;
    n   = m_q.size();
    pop = rd && (n > 0);
    acc = done && ((n < DEPTH) || rd);
    if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(din);
    if (done && !acc) m_ovf = 1;
    else if (clr)     m_ovf = 0;
    if (m_fired) begin
      if (acc || pop) begin
        m_fired  = 0;
        m_silent = 0;
      end
    end else if (done || m_q.size() == 0) begin
      m_silent = 0;
    end else if (tick) begin
      m_silent++;
      if (m_silent == TO_TICKS) begin
        m_fired  = 1;
        m_silent = 0;
      end
    end
  endtask

  // scoreboard
  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    int  sz;
    int  exp_data;
    bit  exp_thr;
    sz       = m_q.size();
    exp_data = (sz > 0) ? int'(m_q[0]) : 0;
    exp_thr  = (m_thr != 0) && (sz >= int'(m_thr));
    check_val({tag, ".count"},   int'(bus.count), sz);
    check_val({tag, ".empty"},   int'(bus.empty), int'(sz == 0));
    check_val({tag, ".full"},    int'(bus.full), int'(sz == DEPTH));
    check_val({tag, ".rd_data"}, int'(bus.rd_data), exp_data);
    check_val({tag, ".ovf"},     int'(bus.overflow), int'(m_ovf));
    check_val({tag, ".thr_irq"}, int'(bus.thresh_irq), int'(exp_thr));
    check_val({tag, ".to_irq"},  int'(bus.timeout_irq), int'(m_fired));
  endtask

  // drivers
  task automatic cyc(input logic done, input logic [7:0] din, input logic rd,
                     input logic tick, input logic clr, input string tag);
    bus.Rx_done_Tick = done;
    bus.Rx_Dout      = din;
    bus.rd_en        = rd;
    S_tick           = tick;
    bus.overflow_clr = clr;
    bus.rx_thresh    = m_thr;
    model_step(done, din, rd, tick, clr);
    @(posedge clk);
    #1;
    bus.Rx_done_Tick = 1'b0;
    bus.rd_en        = 1'b0;
    S_tick           = 1'b0;
    bus.overflow_clr = 1'b0;
    check_model(tag);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #3;
    areset = 1'b0;
    model_reset();
    #1;
    check_model(tag);
    check_val({tag, ".state"}, int'(dbg_state), 0);
    @(posedge clk);
    #1;
    areset = 1'b1;
  endtask

  typedef struct {
    logic       done;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    logic [4:0] thr;
    logic [4:0] e_cnt;
    logic       e_empty;
    logic       e_full;
    logic [7:0] e_data;
    logic       e_ovf;
    logic       e_thr;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int pdone;
    int prd;
    int ptick;
    logic [7:0] d;

    bus.Rx_done_Tick = 1'b0;
    bus.Rx_Dout      = '0;
    bus.rd_en        = 1'b0;
    bus.overflow_clr = 1'b0;
    bus.rx_thresh    = '0;
    m_thr            = '0;
    model_reset();

    //            done din    rd clr thr  cnt emp ful data  ovf thr
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd0, 5'd1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd2, 5'd2, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd1, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h77, 1'b1, 1'b0, 5'd2, 5'd1, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd2, 5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 8'h11, 1'b0, 1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b1};

    // reset state
    #12;
    check_model("reset");
    check_val("reset.state", int'(dbg_state), 0);
    @(posedge clk);
    #1;
    areset = 1'b1;

    // table vectors with hand-computed expectations
    for (int i = 0; i < 7; i++) begin
      m_thr = tbl[i].thr;
      cyc(tbl[i].done, tbl[i].din, tbl[i].rd, 1'b0, tbl[i].clr, "tbl");
      check_val($sformatf("tbl%0d.count", i), int'(bus.count), int'(tbl[i].e_cnt));
      check_val($sformatf("tbl%0d.empty", i), int'(bus.empty), int'(tbl[i].e_empty));
      check_val($sformatf("tbl%0d.full", i), int'(bus.full), int'(tbl[i].e_full));
      check_val($sformatf("tbl%0d.data", i), int'(bus.rd_data), int'(tbl[i].e_data));
      check_val($sformatf("tbl%0d.ovf", i), int'(bus.overflow), int'(tbl[i].e_ovf));
      check_val($sformatf("tbl%0d.thr", i), int'(bus.thresh_irq), int'(tbl[i].e_thr));
    end
    pulse_reset("rst1");
    m_thr = '0;

    // fill, overflow, drain in order, clear
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "fill");
    check_val("fill.full", int'(bus.full), 1);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, "drop");
    check_val("drop.ovf", int'(bus.overflow), 1);
    check_val("drop.count", int'(bus.count), 16);
    for (int i = 0; i < 16; i++) begin
      check_val("drain.data", int'(bus.rd_data), i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain");
    end
    cyc(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, "clr");
    check_val("clr.ovf", int'(bus.overflow), 0);

    // clear coinciding with a drop: set wins
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0, "fill2");
    cyc(1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, "dropclr");
    check_val("dropclr.ovf", int'(bus.overflow), 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "clr2");

    // full with simultaneous write and read
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, "fullrw");
    check_val("fullrw.count", int'(bus.count), 16);
    check_val("fullrw.ovf", int'(bus.overflow), 0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "drain2");
    pulse_reset("rst2");

    // wrap-around at occupancy 3
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "wrap_in");
    for (int i = 3; i < 40; i++) cyc(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, "wrap");
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "wrap_out");

    // threshold
    m_thr = 5'd4;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, "thr");
    check_val("thr3", int'(bus.thresh_irq), 0);
    cyc(1'b1, 8'h23, 1'b0, 1'b0, 1'b0, "thr");
    check_val("thr4", int'(bus.thresh_irq), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "thr");
    check_val("thr_rd", int'(bus.thresh_irq), 0);
    m_thr = 5'd0;
    for (int i = 0; i < 13; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, "thr0");
    check_val("thr0.full", int'(bus.thresh_irq), 0);
    pulse_reset("rst3");

    // character timeout
    cyc(1'b1, 8'h61, 1'b0, 1'b0, 1'b0, "to_w");
    cyc(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, "to_w");
    for (int i = 0; i < TO_TICKS - 1; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "to_tick");
    check_val("to_639", int'(bus.timeout_irq), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "to_tick");
    check_val("to_640", int'(bus.timeout_irq), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, "to_rd");
    check_val("to_rd.irq", int'(bus.timeout_irq), 0);
    check_val("to_rd.count", int'(bus.count), 1);
    for (int i = 0; i < 300; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "to_part");
    pulse_reset("rst_mid");
    for (int i = 0; i < 400; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "to_after");

    // randomized traffic in phases of differing density
    for (int ph = 0; ph < 3; ph++) begin
      pdone = (ph == 0) ? 50 : (ph == 1) ? 70 : 1;
      prd   = (ph == 0) ? 50 : (ph == 1) ? 20 : 1;
      ptick = (ph == 2) ? 100 : 25;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 99) < 3) m_thr = 5'($urandom_range(0, 16));
        d = 8'($urandom_range(0, 255));
        cyc(logic'($urandom_range(0, 99) < pdone), d,
            logic'($urandom_range(0, 99) < prd),
            logic'($urandom_range(0, 99) < ptick),
            logic'($urandom_range(0, 99) < 2), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
